mult_share_arbiter: RTL and testbench

Shares one combinational `multiplier_4bit` instance among `N_REQ` requesters using round-robin arbitration. Each requester presents operands through a valid/ready handshake. The block registers the 8-bit product together with the winning requester's ID and presents it on a single response channel with backpressure. It sits between the operand-producing blocks and the multiplier datapath, and owns all sequencing of that datapath.

---
 rtl/mult_share_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter sharing one 4-bit multiplier among N_REQ requesters
//
// Purpose: N_REQ requesters offer 4-bit operand pairs over valid/ready. A
// combinational round-robin search picks one requester per cycle, its operands
// go through the single shared multiplier_4bit, and the 8-bit product plus the
// requester ID land in a one-entry response register with backpressure.
//
// Ports:
//   clk         in   clock, all state on the rising edge
//   rst         in   asynchronous active-high reset
//   req_valid   in   [N_REQ]   per-requester request
//   req_a       in   [4*N_REQ] operand A, requester i at [4i+3:4i]
//   req_b       in   [4*N_REQ] operand B, same packing
//   req_ready   out  [N_REQ]   one-hot accept (or zero)
//   rsp_valid   out  response register holds a product
//   rsp_p       out  [8]       unsigned product
//   rsp_id      out  [ID_W]    requester that produced rsp_p
//   rsp_ready   in   downstream takes the response
//   stat_count  out  [16]      saturating accept counter
//
// Optional feature macro: MULT_SHARE_STATS_EN enables the accept counter;
// without it stat_count is tied to zero.

module multiplier_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  // Widen before multiplying so the full 8-bit product is kept.
  assign p = {4'b0000, a} * {4'b0000, b};
endmodule

module mult_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [4*N_REQ-1:0]   req_a,
  input  logic [4*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_p,
  output logic [ID_W-1:0]      rsp_id,
  input  logic                 rsp_ready,
  output logic [15:0]          stat_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

  rsp_state_e      state_q, state_d;
  logic [7:0]      rsp_p_q, rsp_p_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            hi_found, lo_found;
  logic [ID_W-1:0] hi_idx, lo_idx, grant_idx;
  logic            space, accept;
  logic [3:0]      mult_a, mult_b;
  logic [7:0]      mult_p;

  // Round-robin search from ptr. Scanning downwards leaves the lowest set
  // index in each variable: hi_* is the first requester at or above ptr,
  // lo_* the first overall, used when the search has to wrap past N_REQ-1.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (ID_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  assign space     = (state_q == EMPTY) || rsp_ready;
  assign accept    = lo_found && space;
  assign req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;

  // Operand mux feeding the single shared multiplier.
  always_comb begin
    mult_a = '0;
    mult_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        mult_a = req_a[4*i +: 4];
        mult_b = req_b[4*i +: 4];
      end
    end
  end

  multiplier_4bit u_mult (
    .a (mult_a),
    .b (mult_b),
    .p (mult_p)
  );

  always_comb begin
    state_d  = state_q;
    rsp_p_d  = rsp_p_q;
    rsp_id_d = rsp_id_q;
    ptr_d    = ptr_q;
    if (accept) begin
      // Covers drain-and-refill too: the new product simply overwrites.
      state_d  = FULL;
      rsp_p_d  = mult_p;
      rsp_id_d = grant_idx;
      ptr_d    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      rsp_p_q  <= '0;
      rsp_id_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      rsp_p_q  <= rsp_p_d;
      rsp_id_q <= rsp_id_d;
      ptr_q    <= ptr_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;

`ifdef MULT_SHARE_STATS_EN
  logic [15:0] stat_count_q, stat_count_d;

  always_comb begin
    stat_count_d = stat_count_q;
    if (accept && (stat_count_q != 16'hFFFF)) begin
      stat_count_d = stat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_count_q <= '0;
    end else begin
      stat_count_q <= stat_count_d;
    end
  end

  assign stat_count = stat_count_q;
`else
  assign stat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - randomized self-checking bench for mult_share_arbiter

module tb_mult_share_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [4*N-1:0]  req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [7:0]      rsp_p;
  logic [IW-1:0]   rsp_id;
  logic            rsp_ready;
  logic [15:0]     stat_count;

  mult_share_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_p      (rsp_p),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .stat_count (stat_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: response register contents, pointer, accept count.
  bit m_valid;
  int m_p, m_id, m_ptr, m_count;

  function automatic int exp_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] r;
    g = exp_grant();
    r = '0;
    if (g >= 0 && (!m_valid || rsp_ready)) r[g] = 1'b1;
    return r;
  endfunction

  function automatic int exp_stat();
`ifdef MULT_SHARE_STATS_EN
    return m_count;
`else
    return 0;
`endif
  endfunction

  function automatic int opnd(input logic [4*N-1:0] v, input int i);
    logic [3:0] x;
    x = v[4*i +: 4];
    return int'(x);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_p = 0; m_id = 0; m_ptr = 0; m_count = 0;
  endtask

  task automatic model_step();
    int g;
    g = exp_grant();
    if (g >= 0 && (!m_valid || rsp_ready)) begin
      m_p     = opnd(req_a, g) * opnd(req_b, g);
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % N;
      if (m_count < 65535) m_count++;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[4*i +: 4] = 4'(a);
    req_b[4*i +: 4] = 4'(b);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total += 5;
    if (rsp_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", rsp_valid); else passed++;
    if (rsp_p !== 8'd0) $display("FAIL reset_p got %0d exp 0", rsp_p); else passed++;
    if (rsp_id !== 2'd0) $display("FAIL reset_id got %0d exp 0", rsp_id); else passed++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b exp 0000", req_ready); else passed++;
    if (stat_count !== 16'd0) $display("FAIL reset_stat got %0d exp 0", stat_count); else passed++;
    #4;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; set_op(0, 3, 5); rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001) $display("FAIL single_ready got %b exp 0001", req_ready); else passed++;
    tick();
    req_valid = '0;
    @(negedge clk);
    total += 3;
    if (rsp_valid !== 1'b1) $display("FAIL single_valid got %0b exp 1", rsp_valid); else passed++;
    if (rsp_p !== 8'd15) $display("FAIL single_p got %0d exp 15", rsp_p); else passed++;
    if (rsp_id !== 2'd0) $display("FAIL single_id got %0d exp 0", rsp_id); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int exp_p [4] = '{15, 15, 30, 0};
    do_reset();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    set_op(0, 3, 5); set_op(1, 15, 1); set_op(2, 10, 3); set_op(3, 0, 15);
    for (int k = 0; k <= 4; k++) begin
      if (k == 4) req_valid = '0;
      @(negedge clk);
      if (k > 0) begin
        total += 3;
        if (rsp_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %0b exp 1", k-1, rsp_valid); else passed++;
        if (rsp_p !== 8'(exp_p[k-1])) $display("FAIL b2b_p[%0d] got %0d exp %0d", k-1, rsp_p, exp_p[k-1]); else passed++;
        if (rsp_id !== 2'(k-1)) $display("FAIL b2b_id[%0d] got %0d exp %0d", k-1, rsp_id, k-1); else passed++;
      end
      if (k < 4) begin
        total++;
        if (req_ready !== 4'(1 << k)) $display("FAIL b2b_ready[%0d] got %b exp %b", k, req_ready, 4'(1 << k)); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int a1, b1;
    do_reset();
    req_valid = 4'b0100; set_op(2, 15, 15); rsp_ready = 1'b0;
    tick();
    a1 = $urandom_range(15); b1 = $urandom_range(15);
    req_valid = 4'b0010; set_op(1, a1, b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total += 4;
      if (rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %0b exp 1", k, rsp_valid); else passed++;
      if (rsp_p !== 8'd225) $display("FAIL bp_p[%0d] got %0d exp 225", k, rsp_p); else passed++;
      if (rsp_id !== 2'd2) $display("FAIL bp_id[%0d] got %0d exp 2", k, rsp_id); else passed++;
      if (req_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got %b exp 0000", k, req_ready); else passed++;
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0010) $display("FAIL bp_release_ready got %b exp 0010", req_ready); else passed++;
    tick();
    req_valid = '0;
    @(negedge clk);
    total += 3;
    if (rsp_valid !== 1'b1) $display("FAIL bp_new_valid got %0b exp 1", rsp_valid); else passed++;
    if (rsp_p !== 8'(a1 * b1)) $display("FAIL bp_new_p got %0d exp %0d", rsp_p, a1 * b1); else passed++;
    if (rsp_id !== 2'd1) $display("FAIL bp_new_id got %0d exp 1", rsp_id); else passed++;
    tick();
  endtask

  task automatic test_wrap();
    int a1, b1, a3, b3;
    do_reset();
    req_valid = 4'b0100; set_op(2, $urandom_range(15), $urandom_range(15)); rsp_ready = 1'b1;
    tick();
    a1 = $urandom_range(15); b1 = $urandom_range(15);
    a3 = $urandom_range(15); b3 = $urandom_range(15);
    req_valid = 4'b1010; set_op(1, a1, b1); set_op(3, a3, b3);
    @(negedge clk);
    total++;
    if (req_ready !== 4'b1000) $display("FAIL wrap_first got %b exp 1000", req_ready); else passed++;
    tick();
    @(negedge clk);
    total += 3;
    if (req_ready !== 4'b0010) $display("FAIL wrap_second got %b exp 0010", req_ready); else passed++;
    if (rsp_id !== 2'd3) $display("FAIL wrap_id3 got %0d exp 3", rsp_id); else passed++;
    if (rsp_p !== 8'(a3 * b3)) $display("FAIL wrap_p3 got %0d exp %0d", rsp_p, a3 * b3); else passed++;
    tick();
    req_valid = '0;
    @(negedge clk);
    total += 2;
    if (rsp_id !== 2'd1) $display("FAIL wrap_id1 got %0d exp 1", rsp_id); else passed++;
    if (rsp_p !== 8'(a1 * b1)) $display("FAIL wrap_p1 got %0d exp %0d", rsp_p, a1 * b1); else passed++;
    tick();
  endtask

  task automatic test_async_reset();
    int a3, b3;
    do_reset();
    req_valid = 4'b0100; set_op(2, 9, 7); rsp_ready = 1'b0;
    tick();
    req_valid = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total += 3;
    if (rsp_valid !== 1'b0) $display("FAIL arst_valid got %0b exp 0", rsp_valid); else passed++;
    if (rsp_p !== 8'd0) $display("FAIL arst_p got %0d exp 0", rsp_p); else passed++;
    if (rsp_id !== 2'd0) $display("FAIL arst_id got %0d exp 0", rsp_id); else passed++;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0; rsp_ready = 1'b1;
    // Pointer back at 0: of requesters 1 and 3, requester 1 comes first.
    req_valid = 4'b1010;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0010) $display("FAIL arst_ptr got %b exp 0010", req_ready); else passed++;
    req_valid = 4'b1000;
    a3 = $urandom_range(15); b3 = $urandom_range(15); set_op(3, a3, b3);
    #1;
    total++;
    if (req_ready !== 4'b1000) $display("FAIL arst_r3_ready got %b exp 1000", req_ready); else passed++;
    tick();
    req_valid = '0;
    @(negedge clk);
    total += 2;
    if (rsp_id !== 2'd3) $display("FAIL arst_r3_id got %0d exp 3", rsp_id); else passed++;
    if (rsp_p !== 8'(a3 * b3)) $display("FAIL arst_r3_p got %0d exp %0d", rsp_p, a3 * b3); else passed++;
    tick();
  endtask

  task automatic test_stats();
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'(1 << $urandom_range(N - 1));
      req_a = 16'($urandom); req_b = 16'($urandom);
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    total++;
`ifdef MULT_SHARE_STATS_EN
    if (stat_count !== 16'd5) $display("FAIL stat_five got %0d exp 5", stat_count); else passed++;
    force dut.stat_count_q = 16'hFFFF;
    #1;
    release dut.stat_count_q;
    m_count = 65535;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    @(negedge clk);
    total++;
    if (stat_count !== 16'hFFFF) $display("FAIL stat_sat got %h exp ffff", stat_count); else passed++;
`else
    if (stat_count !== 16'd0) $display("FAIL stat_off got %0d exp 0", stat_count); else passed++;
`endif
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    do_reset();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] && ($urandom_range(7) != 0)) begin
          req_valid[i] = 1'b1;
        end else begin
          req_valid[i] = ($urandom_range(2) != 0);
          set_op(i, $urandom_range(15), $urandom_range(15));
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      total += 3;
      if (req_ready !== exp_ready()) $display("FAIL rnd_ready c%0d got %b exp %b", c, req_ready, exp_ready()); else passed++;
      if (rsp_valid !== m_valid) $display("FAIL rnd_valid c%0d got %0b exp %0b", c, rsp_valid, m_valid); else passed++;
      if (stat_count !== 16'(exp_stat())) $display("FAIL rnd_stat c%0d got %0d exp %0d", c, stat_count, exp_stat()); else passed++;
      if (m_valid) begin
        total += 2;
        if (rsp_p !== 8'(m_p)) $display("FAIL rnd_p c%0d got %0d exp %0d", c, rsp_p, m_p); else passed++;
        if (rsp_id !== 2'(m_id)) $display("FAIL rnd_id c%0d got %0d exp %0d", c, rsp_id, m_id); else passed++;
      end
      pend = req_valid & ~exp_ready();
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_async_reset();
    test_stats();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
